// File: rtl/bypass_scoreboard.sv
// In-flight register-write tracker with decode-side forwarding, hazard stall and GRF write-back.
// Optional saturating stall/forward counters are built under BYPASS_SCOREBOARD_STATS_EN.
module bypass_scoreboard #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RPORTS = 2,
  parameter int unsigned AW     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_dest,
  input  logic [$clog2(DEPTH)-1:0]  issue_ready_at,
  input  logic [$clog2(DEPTH+1)-1:0] hold_upto,
  input  logic [DEPTH-1:0]          produce_valid,
  input  logic [DEPTH*XLEN-1:0]     produce_data,
  input  logic [RPORTS-1:0]         rd_en,
  input  logic [RPORTS*AW-1:0]      rd_addr,
  input  logic [RPORTS*XLEN-1:0]    rd_grf_data,
  output logic [RPORTS*XLEN-1:0]    rd_data,
  output logic                      hazard_stall,
  output logic                      issue_accept,
  output logic                      wb_en,
  output logic [AW-1:0]             wb_addr,
  output logic [XLEN-1:0]           wb_data,
  output logic [31:0]               stat_stalls,
  output logic [31:0]               stat_fwds
);

  localparam int unsigned RW = $clog2(DEPTH);

  logic [DEPTH-1:0]           valid_q, valid_d, dv_q, dv_d, avail;
  logic [DEPTH-1:0][AW-1:0]   dest_q, dest_d;
  logic [DEPTH-1:0][RW-1:0]   rdy_q, rdy_d;
  logic [DEPTH-1:0][XLEN-1:0] data_q, data_d, eff_data;
  logic [RPORTS-1:0]          port_stall, port_fwd;

  // ready_at travels with the entry for the datapath's benefit only
  logic unused_rdy;
  assign unused_rdy = ^rdy_q;

  always_comb begin
    avail    = '0;
    eff_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      avail[i]    = dv_q[i] | produce_valid[i];
      eff_data[i] = dv_q[i] ? data_q[i] : produce_data[i*XLEN +: XLEN];
    end
  end

  // Ascending scan with a found flag gives the youngest (lowest stage) match priority
  always_comb begin
    logic found;
    found      = 1'b0;
    rd_data    = rd_grf_data;
    port_stall = '0;
    port_fwd   = '0;
    for (int unsigned p = 0; p < RPORTS; p++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!found && rd_en[p] && (rd_addr[p*AW +: AW] != '0) && valid_q[i] &&
            (dest_q[i] == rd_addr[p*AW +: AW])) begin
          found = 1'b1;
          if (avail[i]) begin
            rd_data[p*XLEN +: XLEN] = eff_data[i];
            port_fwd[p]             = 1'b1;
          end else begin
            port_stall[p] = 1'b1;
          end
        end
      end
    end
  end

  assign hazard_stall = |port_stall;
  assign issue_accept = issue_valid & ~hazard_stall & (hold_upto == '0);

  always_comb begin
    int unsigned h;
    h       = 32'(hold_upto);
    valid_d = valid_q;
    dv_d    = dv_q;
    dest_d  = dest_q;
    rdy_d   = rdy_q;
    data_d  = data_q;
    if (h > 0) begin
      if (produce_valid[0] && !dv_q[0]) begin
        dv_d[0]   = 1'b1;
        data_d[0] = produce_data[XLEN-1:0];
      end
    end else begin
      valid_d[0] = issue_accept & (issue_dest != '0);
      dest_d[0]  = issue_dest;
      rdy_d[0]   = issue_ready_at;
      dv_d[0]    = 1'b0;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (i < h) begin
        if (produce_valid[i] && !dv_q[i]) begin
          dv_d[i]   = 1'b1;
          data_d[i] = produce_data[i*XLEN +: XLEN];
        end
      end else if (i == h) begin
        valid_d[i] = 1'b0;
        dv_d[i]    = 1'b0;
      end else begin
        valid_d[i] = valid_q[i-1];
        dest_d[i]  = dest_q[i-1];
        rdy_d[i]   = rdy_q[i-1];
        dv_d[i]    = avail[i-1];
        data_d[i]  = eff_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dv_q    <= '0;
      dest_q  <= '0;
      rdy_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dv_q    <= dv_d;
      dest_q  <= dest_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
    end
  end

  assign wb_en   = valid_q[DEPTH-1] & avail[DEPTH-1];
  assign wb_addr = dest_q[DEPTH-1];
  assign wb_data = eff_data[DEPTH-1];

`ifdef BYPASS_SCOREBOARD_STATS_EN
  logic [31:0] stalls_q, fwds_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q <= '0;
      fwds_q   <= '0;
    end else begin
      if (hazard_stall && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
      if ((|port_fwd) && (fwds_q != '1))    fwds_q   <= fwds_q + 32'd1;
    end
  end

  assign stat_stalls = stalls_q;
  assign stat_fwds   = fwds_q;
`else
  logic unused_fwd;
  assign unused_fwd  = |port_fwd;
  assign stat_stalls = '0;
  assign stat_fwds   = '0;
`endif

endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
- Parametrised in-flight register-write tracker and forwarding network for the pipelined CPU.
- Replaces the per-stage hand-wired forward sources and stall-level logic with one block.
- Tracks DEPTH post-decode stages: 0 = execute, DEPTH-1 = writeback.
- Provides the decode-side forwarded operands, the data-hazard stall and the GRF write-back command.

Parameters:
- DEPTH, 3, number of tracked stages after decode (min 2).
- XLEN, 32, data width.
- RPORTS, 2, number of decode read ports.
- AW, 5, register address width; register 0 is hardwired zero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_dest  in  AW  destination register; 0 = no write.
- issue_ready_at  in  $clog2(DEPTH)  first stage index at which the result is produced.
- hold_upto  in  $clog2(DEPTH+1)  external stall level: entries below this index hold.
- produce_valid  in  DEPTH  bit i: datapath drives the result of the entry currently in stage i.
- produce_data  in  DEPTH*XLEN  slice i: that result.
- rd_en  in  RPORTS  per-port read required.
- rd_addr  in  RPORTS*AW  per-port register address.
- rd_grf_data  in  RPORTS*XLEN  per-port raw GRF output.
- rd_data  out  RPORTS*XLEN  per-port forwarded operand.
- hazard_stall  out  1  decode must hold; a bubble is injected into stage 0.
- issue_accept  out  1  decode instruction entered stage 0 this cycle.
- wb_en  out  1  GRF write enable.
- wb_addr  out  AW  GRF write address.
- wb_data  out  XLEN  GRF write data.
- stat_stalls  out  32  hazard stall cycle count (optional feature).
- stat_fwds  out  32  forward count (optional feature).

Behaviour:
- Entry i (i = 0..DEPTH-1) holds:
  - valid, dest, ready_at, dvalid, data.
- Effective data of entry i:
  - data if dvalid.
  - Else produce_data[i] if produce_valid[i] (same-cycle bypass).
  - Available = dvalid OR produce_valid[i].
- Read port p (combinational):
  - Matches an entry when rd_en[p], rd_addr[p] != 0, entry valid, and dest == rd_addr[p].
  - Youngest match (lowest i) wins.
  - Match available: rd_data = effective data.
  - Match not available: port stalls.
  - No match (including addr 0 or rd_en=0): rd_data = rd_grf_data[p].
- hazard_stall = OR of port stalls; independent of hold_upto.
- issue_accept = issue_valid AND NOT hazard_stall AND hold_upto == 0.
- Clock edge, non-reset: let h = hold_upto.
  - Entries i < h hold their contents, and still capture data: if produce_valid[i] and not dvalid, set dvalid and data.
  - Entry h (if h < DEPTH) becomes a bubble (valid = 0).
  - Entries i > h load entry i-1 contents, with entry i-1's same-cycle produce folded into dvalid/data.
  - When h == 0, entry 0 loads the decode instruction if issue_accept, else a bubble:
    - valid = 1, dest = issue_dest, ready_at = issue_ready_at, dvalid = 0.
    - issue_dest == 0 loads valid = 0.
  - h == DEPTH: all entries hold, no bubble.
- Write-back (combinational from entry DEPTH-1):
  - wb_en = valid AND available.
  - wb_addr = dest.
  - wb_data = effective data.
  - A valid last entry with no data drives wb_en = 0; this is a datapath contract violation.
- Reset:
  - All entries valid = 0, dvalid = 0; counters = 0.
  - Outputs follow immediately: hazard_stall = 0, issue_accept = issue_valid AND hold_upto == 0, wb_en = 0, rd_data = rd_grf_data.
  - Reset mid-operation discards all in-flight entries.
- ready_at is advisory for the datapath only; the block relies solely on produce_valid.

Optional Feature:
- Macro: BYPASS_SCOREBOARD_STATS_EN.
- Defined:
  - stat_stalls increments on every cycle with hazard_stall = 1.
  - stat_fwds increments on every cycle in which at least one port takes data from an entry.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports tied to 0 and no counter logic is built.

Test Plan:
- Reset, then read r3 with grf = 0xAAAA0003 -> rd_data = 0xAAAA0003, hazard_stall = 0, wb_en = 0.
- ALU chain: issue dest = 8 ready_at = 1; next cycle produce_valid[1] = 0 and entry in stage 0 -> read r8 stalls. Following cycle entry in stage 1, produce 0x1234 -> rd_data = 0x1234, hazard_stall = 0.
- Load-use: issue dest = 9; read r9 for 2 cycles -> hazard_stall = 1 for both cycles, bubbles in stage 0. Then stage 2 produce 0xDEADBEEF -> rd_data = 0xDEADBEEF, and the same cycle gives wb_en = 1, wb_addr = 9, wb_data = 0xDEADBEEF.
- Priority: stage 0 dest = 5 produce 0x11, stage 1 dest = 5 dvalid 0x22 -> rd_data = 0x11.
- Zero register: issue dest = 0, read r0 with grf = 0 -> no match, rd_data = 0. Entry arriving at writeback gives wb_en = 0.
- hold_upto = 2 with valid entries in stages 0..2 -> next cycle stages 0 and 1 unchanged, stage 2 bubble (wb_en = 0). hold_upto = 3 -> everything frozen.
